// File: rtl/busio_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store bus arbiter.
// Holds the grant-state encoding and the default bus widths.
package busio_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH      = 32;
  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/busio_arbiter_if.sv
// Requester and memory-bus signal bundle around busio_arbiter.
// master = arbiter view, slave = requesters plus bus slave view.
interface busio_arbiter_if
  import busio_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // instruction fetch side
  logic                  fetch_request;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic                  fetch_abort;
  logic                  fetch_ready;
  logic [DATA_WIDTH-1:0] fetch_data;

  // load/store side
  logic                  mem_request;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_strobe;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // external memory bus
  logic                  bus_valid;
  logic                  bus_write;
  logic [ADDR_WIDTH-1:0] bus_address;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [STRB_WIDTH-1:0] bus_strobe;
  logic                  bus_ready;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    input  fetch_request, fetch_address, fetch_abort,
    output fetch_ready, fetch_data,
    input  mem_request, mem_write, mem_address, mem_wdata, mem_strobe,
    output mem_ready, mem_rdata,
    output bus_valid, bus_write, bus_address, bus_wdata, bus_strobe,
    input  bus_ready, bus_rdata
  );

  modport slave (
    output fetch_request, fetch_address, fetch_abort,
    input  fetch_ready, fetch_data,
    output mem_request, mem_write, mem_address, mem_wdata, mem_strobe,
    input  mem_ready, mem_rdata,
    input  bus_valid, bus_write, bus_address, bus_wdata, bus_strobe,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/busio_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store.
// Data side has priority, bounded by a fetch anti-starvation streak counter.
module busio_arbiter
  import busio_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
  input  logic            clk,
  input  logic            reset,
  busio_arbiter_if.master io
);

  localparam int STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int STREAK_WIDTH = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_STREAK);

  arb_state_e            state_q, state_d;
  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strobe_q, strobe_d;
  logic                  fetch_ready_q, fetch_ready_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  fetch_starved;

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d       = state_q;
    streak_d      = streak_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strobe_d      = strobe_q;
    fetch_ready_d = 1'b0;
    mem_ready_d   = 1'b0;
    fetch_data_d  = fetch_data_q;
    mem_rdata_d   = mem_rdata_q;

    fetch_starved = io.fetch_request && (streak_q == STREAK_MAX);

    case (state_q)
      ST_IDLE: begin
        if (!io.fetch_request) streak_d = '0;
        if (io.mem_request && !fetch_starved) begin
          state_d  = ST_DATA;
          write_d  = io.mem_write;
          addr_d   = io.mem_address;
          wdata_d  = io.mem_wdata;
          strobe_d = io.mem_strobe;
          // only grants taken while a fetch is waiting count toward starvation
          if (io.fetch_request && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
        end else if (io.fetch_request && !io.fetch_abort) begin
          state_d  = ST_FETCH;
          write_d  = 1'b0;
          addr_d   = io.fetch_address;
          wdata_d  = '0;
          strobe_d = '1;
          streak_d = '0;
        end
      end

      ST_FETCH: begin
        if (io.bus_ready) begin
          state_d = ST_IDLE;
          if (!io.fetch_abort) begin
            fetch_ready_d = 1'b1;
            fetch_data_d  = io.bus_rdata;
          end
        end else if (io.fetch_abort) begin
          // the slave already saw the beat; finish it silently
          state_d = ST_DRAIN;
        end
      end

      ST_DATA: begin
        if (io.bus_ready) begin
          state_d     = ST_IDLE;
          mem_ready_d = 1'b1;
          mem_rdata_d = io.bus_rdata;
        end
      end

      ST_DRAIN: begin
        if (io.bus_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      streak_q      <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strobe_q      <= '0;
      fetch_ready_q <= 1'b0;
      mem_ready_q   <= 1'b0;
      fetch_data_q  <= '0;
      mem_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strobe_q      <= strobe_d;
      fetch_ready_q <= fetch_ready_d;
      mem_ready_q   <= mem_ready_d;
      fetch_data_q  <= fetch_data_d;
      mem_rdata_q   <= mem_rdata_d;
    end
  end

  // bus_valid decodes straight from the state flop, so async reset drops it at once
  assign io.bus_valid   = (state_q != ST_IDLE);
  assign io.bus_write   = write_q;
  assign io.bus_address = addr_q;
  assign io.bus_wdata   = wdata_q;
  assign io.bus_strobe  = strobe_q;
  assign io.fetch_ready = fetch_ready_q;
  assign io.fetch_data  = fetch_data_q;
  assign io.mem_ready   = mem_ready_q;
  assign io.mem_rdata   = mem_rdata_q;

endmodule
